// File: rtl/pll_lock_supervisor_if.sv
// PLL lock/reset bundle: the supervisor (master) drives the resets, status and debug counters,
// and the PLL/board side (slave) drives the lock flag and relock request.
interface pll_lock_supervisor_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             relock_req;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             ready;
  logic [CNT_W-1:0] loss_count;
  logic [CNT_W-1:0] timeout_count;
  logic [1:0]       state;

  modport master (
    input  pll_locked, relock_req,
    output pll_rst, sys_rst_n, ready, loss_count, timeout_count, state
  );

  modport slave (
    output pll_locked, relock_req,
    input  pll_rst, sys_rst_n, ready, loss_count, timeout_count, state
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Resets the PLL, waits for a stable lock, then releases the system reset.
// Lock loss, lock timeout or a relock request sends it back to resetting the PLL.
module pll_lock_supervisor #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int RELOCK_TIMEOUT     = 65536,
  parameter int CNT_W              = 8
) (
  input logic                   refclk,
  input logic                   rst,
  pll_lock_supervisor_if.master bus
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_e;

  // One shared counter serves all three timed states, so it is sized for the longest.
  localparam int MAX_A = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                                  : RESET_HOLD_CYCLES;
  localparam int MAX_N = (MAX_A > RELOCK_TIMEOUT) ? MAX_A : RELOCK_TIMEOUT;
  localparam int CW    = (MAX_N > 2) ? $clog2(MAX_N) : 1;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(RELOCK_TIMEOUT - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             pll_rst_q;
  logic             run_q;
  logic [CNT_W-1:0] loss_q;
  logic [CNT_W-1:0] tout_q;
  logic             sync_q;
  logic             locked_s;
  logic             timeout_hit;
  logic             loss_hit;

  // pll_locked comes from the PLL's own timing domain; only the second flop is trusted.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep the two flops a real two-stage chain.
      sync_q   <= bus.pll_locked;
      locked_s <= sync_q;
    end
  end

  // Counter events are judged independently of relock_req, so a coinciding request still counts.
  assign timeout_hit = (state_q == WAIT_LOCK) && !locked_s && (cnt_q == TIMEOUT_LAST);
  assign loss_hit    = (state_q == RUN) && !locked_s;

  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      run_q     <= 1'b0;
      loss_q    <= '0;
      tout_q    <= '0;
    end else begin
      if (loss_hit && (loss_q != {CNT_W{1'b1}}))
        loss_q <= loss_q + 1'b1;
      if (timeout_hit && (tout_q != {CNT_W{1'b1}}))
        tout_q <= tout_q + 1'b1;

      if (bus.relock_req && (state_q != RESET_PLL)) begin
        state_q   <= RESET_PLL;
        cnt_q     <= '0;
        pll_rst_q <= 1'b1;
        run_q     <= 1'b0;
      end else begin
        case (state_q)
          RESET_PLL: begin
            if (cnt_q == HOLD_LAST) begin
              state_q   <= WAIT_LOCK;
              cnt_q     <= '0;
              pll_rst_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (locked_s) begin
              state_q <= STABILIZE;
              cnt_q   <= '0;
            end else if (timeout_hit) begin
              state_q   <= RESET_PLL;
              cnt_q     <= '0;
              pll_rst_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          STABILIZE: begin
            if (!locked_s) begin
              state_q <= WAIT_LOCK;
              cnt_q   <= '0;
            end else if (cnt_q == STABLE_LAST) begin
              state_q <= RUN;
              cnt_q   <= '0;
              run_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RUN: begin
            if (!locked_s) begin
              state_q   <= RESET_PLL;
              cnt_q     <= '0;
              pll_rst_q <= 1'b1;
              run_q     <= 1'b0;
            end
          end
          default: begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            run_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  // Outputs come straight from flops that track the state, so downstream resets never glitch.
  assign bus.pll_rst       = pll_rst_q;
  assign bus.sys_rst_n     = run_q;
  assign bus.ready         = run_q;
  assign bus.loss_count    = loss_q;
  assign bus.timeout_count = tout_q;
  assign bus.state         = state_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Consumer and controller of a PLL's lock/reset interface. It drives the PLL reset, watches the PLL locked flag, and releases a system reset only after lock has been continuously stable. On lock loss, lock timeout, or a software relock request, it re-resets the PLL, and it keeps saturating event counters for debug. It runs in the 50 MHz reference clock domain and sits between the board reset and every block clocked by the PLL outputs.

Parameters:
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release (>=2)
RESET_HOLD_CYCLES, 16, pll_rst pulse width in refclk cycles per reset entry (>=1)
RELOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before the PLL is reset again (>=2)
CNT_W, 8, width of the event counters

Ports:
refclk  in  1  reference clock, 50 MHz; the only clock
rst  in  1  asynchronous, active-low reset
pll_locked  in  1  PLL locked flag, asynchronous to refclk
relock_req  in  1  synchronous request to re-reset the PLL (level, sampled each cycle)
pll_rst  out  1  active-high reset to the PLL
sys_rst_n  out  1  active-low system reset for downstream logic
ready  out  1  high while in RUN
loss_count  out  CNT_W  lock losses seen in RUN, saturating
timeout_count  out  CNT_W  lock timeouts seen in WAIT_LOCK, saturating
state  out  2  debug state code: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABILIZE, 3 RUN

Behaviour:
- Reset (rst=0, async) forces:
  - state=RESET_PLL, internal counter=0, synchronizer flops=0
  - pll_rst=1, sys_rst_n=0, ready=0, loss_count=0, timeout_count=0
- pll_locked passes through a 2-flop synchronizer into locked_s. Only locked_s is used.
- pll_rst = (state==RESET_PLL). sys_rst_n = ready = (state==RUN). All are decoded from registered state, so there are no glitches.
- RESET_PLL:
  - The counter runs from 0 to RESET_HOLD_CYCLES-1, then the state goes to WAIT_LOCK with the counter cleared.
  - pll_rst is high for exactly RESET_HOLD_CYCLES cycles per entry; after power-up this is in addition to the time rst is held low.
  - relock_req is ignored in this state.
- WAIT_LOCK:
  - locked_s=1 -> STABILIZE, counter cleared.
  - Otherwise, if counter==RELOCK_TIMEOUT-1 -> RESET_PLL and timeout_count increments (saturating).
  - Otherwise the counter increments.
- STABILIZE:
  - locked_s=0 -> WAIT_LOCK with the counter cleared (timeout restarts); no counter increments.
  - locked_s=1 and counter==LOCK_STABLE_CYCLES-1 -> RUN.
  - Otherwise the counter increments.
- RUN: stays in RUN while locked_s=1. locked_s=0 -> RESET_PLL and loss_count increments (saturating).
- relock_req=1 in WAIT_LOCK, STABILIZE or RUN -> RESET_PLL next cycle, and it overrides every other transition.
  - If relock_req and locked_s=0 coincide in RUN, loss_count still increments.
  - If relock_req and a timeout coincide in WAIT_LOCK, timeout_count still increments.
- Both counters saturate at 2^CNT_W-1 and never wrap. They clear only on rst.
- Latency: ready rises LOCK_STABLE_CYCLES+3 refclk edges after the first edge that samples pll_locked=1 (2 sync + 1 transition + stable count), provided pll_locked stays high.
- Lock drop in RUN: ready falls 3 edges after the first sampling edge of pll_locked=0 (2 sync + 1 transition).
- A pll_locked glitch shorter than one cycle may or may not be captured. If it is captured in RUN, it counts as a loss.

Test Plan:
Params for all tests: LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, RELOCK_TIMEOUT=32, CNT_W=4.
1. Release rst with pll_locked=0 -> pll_rst high for exactly 4 cycles, then state=1. Hold pll_locked=0 -> after 32 cycles in WAIT_LOCK, pll_rst pulses again for 4 cycles and timeout_count=1. Repeat 20 timeouts -> timeout_count saturates at 15.
2. Raise pll_locked after the first pll_rst pulse and hold it -> state goes 1->2->3. ready and sys_rst_n rise 11 edges (±1) after the pll_locked rise. loss_count=0.
3. In STABILIZE, drop pll_locked for 3 cycles after 5 stable cycles -> state returns to 1 and ready stays 0. Re-raise -> the full 8-cycle stabilization restarts. No counter changes.
4. In RUN, drop pll_locked -> ready=0 within 3 edges, state=0, pll_rst pulses 4 cycles, loss_count=1. Re-lock -> RUN again.
5. Pulse relock_req for 1 cycle in RUN -> RESET_PLL next cycle and loss_count unchanged. Pulse relock_req together with a pll_locked drop (timed so locked_s=0 in the same cycle) -> loss_count increments by 1.
6. Assert rst mid-STABILIZE, and separately mid-RUN -> all outputs return to reset values immediately (asynchronously) and both counters=0. On release, the 4-cycle pll_rst sequence restarts.
